dma_regbus_arbiter: RTL and testbench

- Shares the DMA controller's single internal register-bus port between two requesters.
- Requester 0 is the AXI4-Lite slave control path; requester 1 is the internal descriptor/status engine.
- Each transfer is a single 32-bit read or write: arbitrated, issued downstream with a valid/ready handshake, then acknowledged back to its requester.
- Sits between the AXI4-Lite slave controller, the descriptor engine and the register bank.

---
 rtl/dma_regbus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_dma_regbus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_regbus_arbiter.sv
// ---------------------------------------------------------------------------
// dma_regbus_arbiter
//
// Shares the DMA controller's single internal register-bus port between two
// requesters: requester 0 (AXI4-Lite slave control path) and requester 1
// (descriptor/status engine). Each transfer is one 32-bit read or write that
// is arbitrated, issued downstream with a valid/ready handshake, and then
// acknowledged to its requester with a one-cycle ACK pulse.
//
// Parameters:
//   PRIORITY_MODE   0 = round-robin, 1 = fixed priority (requester 0 wins)
//   TIMEOUT_CYCLES  ISSUE cycles before a forced SLVERR (2..65535), only
//                   meaningful when the optional timeout is compiled in
//
// Optional feature macro: DMA_REGBUS_TIMEOUT_EN
//   Defined   -> a 16-bit counter aborts a stalled ISSUE with RESP=10.
//   Undefined -> ISSUE waits for reg_ready indefinitely; RESP is always 00.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req0/1, wr0/1, addr0/1,
//   wdata0/1, strb0/1           requester transfer requests and fields
//   ack0/1                      one-cycle completion pulses
//   rdata, resp                 shared read data / response, valid with ack
//   reg_valid, reg_wr, reg_addr,
//   reg_wdata, reg_strb         downstream request
//   reg_ready, reg_rdata        downstream accept / read data
//   grant                       index of the current or last owner
// ---------------------------------------------------------------------------
module dma_regbus_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  strb0,
  input  logic [3:0]  strb1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  output logic        reg_valid,
  output logic        reg_wr,
  output logic [10:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_strb,
  input  logic        reg_ready,
  input  logic [31:0] reg_rdata,
  output logic        grant
);

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_ISSUE = 3'b010;
  localparam logic [2:0] ST_RESP  = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Catch a timeout setting the 16-bit counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dma_regbus_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  logic [2:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic        wr_q, wr_d;
  logic [10:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        pick1;

`ifdef DMA_REGBUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Arbitration: a lone request always wins; under contention either
  // requester 0 wins outright or the one that was not served last wins.
  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
      if (PRIORITY_MODE == 1) begin
        pick1 = 1'b0;
      end else begin
        pick1 = ~last_q;
      end
    end else begin
      pick1 = req1;
    end
  end

  // Next-state logic. The winning requester's fields are latched on grant so
  // the downstream request stays stable even if the requester misbehaves and
  // drops its request before the acknowledge.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
`ifdef DMA_REGBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d = pick1;
          wr_d    = pick1 ? wr1 : wr0;
          // Word-align by masking the byte-lane bits.
          addr_d  = (pick1 ? addr1 : addr0) & 11'h7FC;
          wdata_d = pick1 ? wdata1 : wdata0;
          strb_d  = (pick1 ? wr1 : wr0) ? (pick1 ? strb1 : strb0) : 4'b0000;
          state_d = ST_ISSUE;
`ifdef DMA_REGBUS_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      ST_ISSUE: begin
        // A ready in the final timeout cycle still completes normally.
        if (reg_ready) begin
          rdata_d = wr_q ? 32'h0 : reg_rdata;
          resp_d  = RESP_OKAY;
          state_d = ST_RESP;
        end
`ifdef DMA_REGBUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = 32'h0;
          resp_d  = RESP_SLVERR;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and hold registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 11'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      rdata_q <= 32'h0;
      resp_q  <= RESP_OKAY;
`ifdef DMA_REGBUS_TIMEOUT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
`ifdef DMA_REGBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs come straight from state and hold registers, so valid and ack
  // can never overlap and everything is zero while reset is asserted.
  assign reg_valid = (state_q == ST_ISSUE);
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_strb  = strb_q;
  assign ack0      = (state_q == ST_RESP) && !grant_q;
  assign ack1      = (state_q == ST_RESP) && grant_q;
  assign rdata     = rdata_q;
  assign resp      = resp_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_dma_regbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_regbus_arbiter
//
// Self-checking bench for dma_regbus_arbiter. A round-robin instance (dut)
// is checked throughout; a fixed-priority instance (dut_fp) shares the same
// inputs and is checked under continuous contention. Directed scenarios are
// followed by a randomized run against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_dma_regbus_arbiter;

`ifdef DMA_REGBUS_TIMEOUT_EN
  localparam int TO_CYC  = 4;
  localparam int RD_WAIT = 3;
`else
  localparam int TO_CYC  = 256;
  localparam int RD_WAIT = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [10:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  strb0, strb1;
  logic        reg_ready;
  logic [31:0] reg_rdata;

  logic        ack0, ack1, reg_valid, reg_wr, grant;
  logic [31:0] rdata, reg_wdata;
  logic [1:0]  resp;
  logic [10:0] reg_addr;
  logic [3:0]  reg_strb;

  logic        fp_ack0, fp_ack1, fp_reg_valid, fp_reg_wr, fp_grant;
  logic [31:0] fp_rdata, fp_reg_wdata;
  logic [1:0]  fp_resp;
  logic [10:0] fp_reg_addr;
  logic [3:0]  fp_reg_strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_regbus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .strb0(strb0), .strb1(strb1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .resp(resp),
    .reg_valid(reg_valid), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_strb(reg_strb),
    .reg_ready(reg_ready), .reg_rdata(reg_rdata), .grant(grant)
  );

  dma_regbus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO_CYC)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .strb0(strb0), .strb1(strb1),
    .ack0(fp_ack0), .ack1(fp_ack1), .rdata(fp_rdata), .resp(fp_resp),
    .reg_valid(fp_reg_valid), .reg_wr(fp_reg_wr), .reg_addr(fp_reg_addr),
    .reg_wdata(fp_reg_wdata), .reg_strb(fp_reg_strb),
    .reg_ready(reg_ready), .reg_rdata(reg_rdata), .grant(fp_grant)
  );

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one requester's request line and transfer fields.
  task automatic applyStimulus(input int who, input logic r, input logic w,
                               input logic [10:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    if (who == 0) begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d; strb0 = s;
    end else begin
      req1 = r; wr1 = w; addr1 = a; wdata1 = d; strb1 = s;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {26'h0, ack0, ack1, reg_valid, reg_wr, grant, resp[1]}, 32'h0);
    checkOutput({tag, "_resp"}, {30'h0, resp}, 32'h0);
    checkOutput({tag, "_rdata"}, rdata, 32'h0);
    checkOutput({tag, "_addr"}, {21'h0, reg_addr}, 32'h0);
    checkOutput({tag, "_wdata"}, reg_wdata, 32'h0);
    checkOutput({tag, "_strb"}, {28'h0, reg_strb}, 32'h0);
  endtask

  // Random-phase state: outstanding transaction per requester.
  logic        t_wr[2];
  logic [10:0] t_addr[2];
  logic [31:0] t_wdata[2];
  logic [3:0]  t_strb[2];
  logic        pend[2];
  int          gap[2];

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  p_req;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic        m_last, m_owner, w;
    int          phase, w_cnt;

    rst = 1'b1;
    reg_ready = 1'b0;
    reg_rdata = 32'h0;
    applyStimulus(0, 0, 0, 11'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 11'h0, 32'h0, 4'h0);
    #12;
    checkAllZero("reset");
    tick();
    rst = 1'b0;

    // Single write, downstream always ready.
    applyStimulus(0, 1, 1, 11'h013, 32'hA5A5_0001, 4'hF);
    reg_ready = 1'b1;
    tick();
    checkOutput("wr_valid", reg_valid, 1);
    checkOutput("wr_regwr", reg_wr, 1);
    checkOutput("wr_addr", reg_addr, 11'h010);
    checkOutput("wr_wdata", reg_wdata, 32'hA5A5_0001);
    checkOutput("wr_strb", reg_strb, 4'hF);
    checkOutput("wr_grant", grant, 0);
    checkOutput("wr_noack", {ack0, ack1}, 2'b00);
    tick();
    checkOutput("wr_ack", {ack0, ack1}, 2'b10);
    checkOutput("wr_valid_off", reg_valid, 0);
    checkOutput("wr_resp", resp, 2'b00);
    checkOutput("wr_rdata", rdata, 32'h0);
    applyStimulus(0, 0, 0, 11'h0, 32'h0, 4'h0);
    tick();
    checkOutput("wr_ack_once", {ack0, ack1}, 2'b00);
    tick();
    checkOutput("idle_ready_ignored", reg_valid, 0);

    // Read with a slow downstream; strobes must be suppressed.
    reg_ready = 1'b0;
    applyStimulus(1, 1, 0, 11'h020, 32'h1111_2222, 4'hF);
    for (int i = 0; i < RD_WAIT; i++) begin
      tick();
      checkOutput("rd_valid", reg_valid, 1);
      checkOutput("rd_addr", reg_addr, 11'h020);
      checkOutput("rd_strb", reg_strb, 4'h0);
      checkOutput("rd_wr", reg_wr, 0);
      checkOutput("rd_grant", grant, 1);
      checkOutput("rd_noack", {ack0, ack1}, 2'b00);
      if (i == RD_WAIT - 1) begin
        reg_ready = 1'b1;
        reg_rdata = 32'hDEAD_BEEF;
      end
    end
    tick();
    checkOutput("rd_ack", {ack0, ack1}, 2'b01);
    checkOutput("rd_rdata", rdata, 32'hDEAD_BEEF);
    checkOutput("rd_resp", resp, 2'b00);
    checkOutput("rd_no_overlap", reg_valid, 0);
    applyStimulus(1, 0, 0, 11'h0, 32'h0, 4'h0);
    reg_ready = 1'b0;
    reg_rdata = 32'h0;
    tick();

    // Continuous contention: round-robin alternates, fixed priority starves 1.
    applyStimulus(0, 1, 0, 11'h004, 32'h0, 4'h0);
    applyStimulus(1, 1, 0, 11'h008, 32'h0, 4'h0);
    reg_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 3 == 2) begin
        checkOutput("rr_ack", {ack0, ack1}, ((k / 3) % 2 == 0) ? 2'b10 : 2'b01);
        checkOutput("fp_ack", {fp_ack0, fp_ack1}, 2'b10);
      end else begin
        checkOutput("rr_noack", {ack0, ack1}, 2'b00);
        checkOutput("fp_noack", {fp_ack0, fp_ack1}, 2'b00);
      end
      checkOutput("rr_valid", reg_valid, (k % 3 == 1) ? 1'b1 : 1'b0);
    end
    applyStimulus(0, 0, 0, 11'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 11'h0, 32'h0, 4'h0);
    reg_ready = 1'b0;
    tick();
    tick();

    // Reset during ISSUE aborts the transfer; pointer returns to favour 0.
    applyStimulus(1, 1, 0, 11'h044, 32'h0, 4'h0);
    tick();
    checkOutput("rst_pre_grant", grant, 1);
    checkOutput("rst_pre_valid", reg_valid, 1);
    applyStimulus(0, 1, 0, 11'h1FF, 32'h0, 4'h0);
    #2 rst = 1'b1;
    #1 checkAllZero("rst_mid");
    tick();
    checkOutput("rst_hold_noack", {ack0, ack1}, 2'b00);
    rst = 1'b0;
    tick();
    checkOutput("rst_after_grant", grant, 0);
    checkOutput("rst_after_valid", reg_valid, 1);
    checkOutput("rst_after_addr", reg_addr, 11'h1FC);
    reg_ready = 1'b1;
    reg_rdata = 32'h1234_5678;
    tick();
    checkOutput("rst_after_ack", {ack0, ack1}, 2'b10);
    checkOutput("rst_after_rdata", rdata, 32'h1234_5678);
    applyStimulus(0, 0, 0, 11'h0, 32'h0, 4'h0);
    reg_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_pending1_grant", grant, 1);
    checkOutput("rst_pending1_valid", reg_valid, 1);
    reg_ready = 1'b1;
    reg_rdata = 32'h0BAD_F00D;
    tick();
    checkOutput("rst_pending1_ack", {ack0, ack1}, 2'b01);
    checkOutput("rst_pending1_rdata", rdata, 32'h0BAD_F00D);
    applyStimulus(1, 0, 0, 11'h0, 32'h0, 4'h0);
    reg_ready = 1'b0;
    tick();

    // Stalled downstream: timeout error or indefinite wait.
    applyStimulus(0, 1, 0, 11'h100, 32'h0, 4'h0);
`ifdef DMA_REGBUS_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("to_valid", reg_valid, 1);
      checkOutput("to_noack", {ack0, ack1}, 2'b00);
    end
    tick();
    checkOutput("to_ack", {ack0, ack1}, 2'b10);
    checkOutput("to_resp", resp, 2'b10);
    checkOutput("to_rdata", rdata, 32'h0);
    checkOutput("to_valid_off", reg_valid, 0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("stall_valid", reg_valid, 1);
      checkOutput("stall_noack", {ack0, ack1}, 2'b00);
    end
    reg_ready = 1'b1;
    reg_rdata = 32'hCAFE_0001;
    tick();
    checkOutput("stall_ack", {ack0, ack1}, 2'b10);
    checkOutput("stall_resp", resp, 2'b00);
    checkOutput("stall_rdata", rdata, 32'hCAFE_0001);
`endif
    applyStimulus(0, 0, 0, 11'h0, 32'h0, 4'h0);
    reg_ready = 1'b0;
    reg_rdata = 32'h0;
    tick();

    // Randomized traffic against a transaction-level model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0;
      gap[r] = $urandom_range(0, 2);
      t_wr[r] = 1'b0; t_addr[r] = 11'h0; t_wdata[r] = 32'h0; t_strb[r] = 4'h0;
    end
    p_req = 2'b00; p_ready = 1'b0; p_rdata = 32'h0;
    m_last = 1'b1; m_owner = 1'b0; phase = 0; w_cnt = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acked;
      tick();
      acked = 1'b0;
      if (phase == 0) begin
        if (p_req != 2'b00) begin
          w = (p_req == 2'b11) ? ~m_last : p_req[1];
          checkOutput("rnd_valid", reg_valid, 1);
          checkOutput("rnd_grant", grant, w);
          checkOutput("rnd_wr", reg_wr, t_wr[w]);
          checkOutput("rnd_addr", reg_addr, {t_addr[w][10:2], 2'b00});
          checkOutput("rnd_strb", reg_strb, t_wr[w] ? t_strb[w] : 4'h0);
          if (t_wr[w]) checkOutput("rnd_wdata", reg_wdata, t_wdata[w]);
          m_owner = w;
          phase = 1;
          w_cnt = 0;
        end else begin
          checkOutput("rnd_idle", {reg_valid, ack0, ack1}, 3'b000);
        end
      end else if (phase == 1) begin
        if (p_ready) begin
          checkOutput("rnd_ack", {ack0, ack1}, m_owner ? 2'b01 : 2'b10);
          checkOutput("rnd_rdata", rdata, t_wr[m_owner] ? 32'h0 : p_rdata);
          checkOutput("rnd_resp", resp, 2'b00);
          checkOutput("rnd_valid_off", reg_valid, 0);
          m_last = m_owner;
          acked = 1'b1;
          phase = 2;
        end else begin
          checkOutput("rnd_wait", {reg_valid, ack0, ack1}, 3'b100);
          checkOutput("rnd_wait_addr", reg_addr, {t_addr[m_owner][10:2], 2'b00});
        end
      end else begin
        checkOutput("rnd_back_idle", {reg_valid, ack0, ack1}, 3'b000);
        phase = 0;
      end

      if (acked) begin
        pend[m_owner] = 1'b0;
        gap[m_owner] = $urandom_range(0, 2);
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if (gap[r] > 0) begin
            gap[r]--;
          end else begin
            t_wr[r] = 1'($urandom_range(0, 1));
            t_addr[r] = 11'($urandom);
            t_wdata[r] = $urandom;
            t_strb[r] = 4'($urandom);
            pend[r] = 1'b1;
          end
        end
      end
      applyStimulus(0, pend[0], t_wr[0], t_addr[0], t_wdata[0], t_strb[0]);
      applyStimulus(1, pend[1], t_wr[1], t_addr[1], t_wdata[1], t_strb[1]);
      if (phase == 1) begin
        reg_ready = (w_cnt >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        w_cnt++;
      end else begin
        reg_ready = 1'($urandom_range(0, 1));
      end
      reg_rdata = $urandom;
      p_req = {pend[1], pend[0]};
      p_ready = reg_ready;
      p_rdata = reg_rdata;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
